// File: rtl/cmd_frame_parser.sv
// UART command-frame parser: START, LEN, CMD, payload[LEN], END.
// Emits command strobe/level, payload stream and classified frame errors.
module cmd_frame_parser #(
  parameter int                DATA_W      = 8,
  parameter int                NUM_CMDS    = 5,
  parameter int                MAX_PAYLOAD = 16,
  parameter logic [DATA_W-1:0] START_CODE  = 8'hFE,
  parameter logic [DATA_W-1:0] END_CODE    = 8'hEF,
  parameter int                TIMEOUT_CYC = 1_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              uart_data,
  input  logic                           rx_interrupt,
  output logic                           clear_interrupt,
  output logic                           cmd_valid,
  output logic [NUM_CMDS-1:0]            cmd_onehot,
  output logic [DATA_W-1:0]              pay_data,
  output logic                           pay_valid,
  output logic [$clog2(MAX_PAYLOAD)-1:0] pay_idx,
  output logic                           frame_err,
  output logic [1:0]                     err_code
);

  localparam int IW = $clog2(MAX_PAYLOAD);
  localparam int LW = $clog2(MAX_PAYLOAD + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [DATA_W-1:0] MAXP    = DATA_W'(MAX_PAYLOAD);
  localparam logic [DATA_W-1:0] NCMD    = DATA_W'(NUM_CMDS);
  localparam logic [LW-1:0]     LEN_ONE = LW'(1);
  localparam logic [TW-1:0]     TO_ONE  = TW'(1);
  localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {
    HS_WAIT,
    HS_TAKE
  } hs_t;

  typedef enum logic [2:0] {
    F_IDLE,
    F_LEN,
    F_CMD,
    F_PAY,
    F_END
  } fr_t;

  typedef enum logic [1:0] {
    E_BAD_CMD = 2'd0,
    E_BAD_LEN = 2'd1,
    E_BAD_END = 2'd2,
    E_TIMEOUT = 2'd3
  } err_t;

  hs_t               r_hs, w_hs_n;
  fr_t               r_fr, w_fr_n;
  logic [LW-1:0]     r_len, w_len_n;
  logic [DATA_W-1:0] r_code, w_code_n;
  logic [LW-1:0]     r_cnt, w_cnt_n;
  logic [TW-1:0]     r_to, w_to_n;

  logic                r_cv, w_cv_n;
  logic [NUM_CMDS-1:0] r_oh, w_oh_n;
  logic [DATA_W-1:0]   r_pd, w_pd_n;
  logic                r_pv, w_pv_n;
  logic [IW-1:0]       r_pi, w_pi_n;
  logic                r_fe, w_fe_n;
  logic [1:0]          r_ec, w_ec_n;

  logic                w_abort;
  err_t                w_abort_code;
  logic [NUM_CMDS-1:0] w_dec;

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      w_dec[i] = (r_code == DATA_W'(i + 1));
    end
  end

  always_comb begin
    w_hs_n       = r_hs;
    w_fr_n       = r_fr;
    w_len_n      = r_len;
    w_code_n     = r_code;
    w_cnt_n      = r_cnt;
    w_to_n       = r_to;
    w_cv_n       = 1'b0;
    w_oh_n       = r_oh;
    w_pd_n       = r_pd;
    w_pv_n       = 1'b0;
    w_pi_n       = r_pi;
    w_fe_n       = 1'b0;
    w_ec_n       = r_ec;
    w_abort      = 1'b0;
    w_abort_code = E_BAD_CMD;

    unique case (r_hs)
      HS_WAIT: begin
        // a pending byte always beats an expiring timeout
        if (rx_interrupt) begin
          w_hs_n = HS_TAKE;
        end else if (TIMEOUT_CYC != 0 && r_fr != F_IDLE) begin
          if (r_to == TO_LAST) begin
            w_abort      = 1'b1;
            w_abort_code = E_TIMEOUT;
          end else begin
            w_to_n = r_to + TO_ONE;
          end
        end
      end
      HS_TAKE: begin
        w_hs_n = HS_WAIT;
        w_to_n = '0;
        unique case (r_fr)
          F_IDLE: begin
            if (uart_data == START_CODE) w_fr_n = F_LEN;
          end
          F_LEN: begin
            if (uart_data > MAXP) begin
              w_abort      = 1'b1;
              w_abort_code = E_BAD_LEN;
            end else begin
              w_len_n = LW'(uart_data);
              w_cnt_n = '0;
              w_fr_n  = F_CMD;
            end
          end
          F_CMD: begin
            if (uart_data == '0 || uart_data > NCMD) begin
              w_abort      = 1'b1;
              w_abort_code = E_BAD_CMD;
            end else begin
              w_code_n = uart_data;
              w_fr_n   = (r_len != '0) ? F_PAY : F_END;
            end
          end
          F_PAY: begin
            w_pv_n  = 1'b1;
            w_pd_n  = uart_data;
            w_pi_n  = r_cnt[IW-1:0];
            w_cnt_n = r_cnt + LEN_ONE;
            if (r_cnt == r_len - LEN_ONE) w_fr_n = F_END;
          end
          F_END: begin
            if (uart_data == END_CODE) begin
              w_cv_n = 1'b1;
              w_oh_n = w_dec;
            end else begin
              w_abort      = 1'b1;
              w_abort_code = E_BAD_END;
            end
            w_fr_n = F_IDLE;
          end
          default: w_fr_n = F_IDLE;
        endcase
      end
      default: w_hs_n = HS_WAIT;
    endcase

    if (w_abort) begin
      w_fe_n   = 1'b1;
      w_ec_n   = w_abort_code;
      w_fr_n   = F_IDLE;
      w_len_n  = '0;
      w_code_n = '0;
      w_cnt_n  = '0;
      w_to_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs   <= HS_WAIT;
      r_fr   <= F_IDLE;
      r_len  <= '0;
      r_code <= '0;
      r_cnt  <= '0;
      r_to   <= '0;
      r_cv   <= 1'b0;
      r_oh   <= '0;
      r_pd   <= '0;
      r_pv   <= 1'b0;
      r_pi   <= '0;
      r_fe   <= 1'b0;
      r_ec   <= '0;
    end else begin
      r_hs   <= w_hs_n;
      r_fr   <= w_fr_n;
      r_len  <= w_len_n;
      r_code <= w_code_n;
      r_cnt  <= w_cnt_n;
      r_to   <= w_to_n;
      r_cv   <= w_cv_n;
      r_oh   <= w_oh_n;
      r_pd   <= w_pd_n;
      r_pv   <= w_pv_n;
      r_pi   <= w_pi_n;
      r_fe   <= w_fe_n;
      r_ec   <= w_ec_n;
    end
  end

  assign clear_interrupt = (r_hs == HS_TAKE);
  assign cmd_valid       = r_cv;
  assign cmd_onehot      = r_oh;
  assign pay_data        = r_pd;
  assign pay_valid       = r_pv;
  assign pay_idx         = r_pi;
  assign frame_err       = r_fe;
  assign err_code        = r_ec;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: byte-level frame model, per-cycle compare,
// directed frames with literal expectations and randomized frame traffic.
module tb_cmd_frame_parser;

  localparam int TO   = 20;
  localparam int MAXP = 16;
  localparam int NCMD = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] uart_data;
  logic       rx_interrupt;
  logic       clear_interrupt;
  logic       cmd_valid;
  logic [4:0] cmd_onehot;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic [3:0] pay_idx;
  logic       frame_err;
  logic [1:0] err_code;

  cmd_frame_parser #(
    .DATA_W(8), .NUM_CMDS(NCMD), .MAX_PAYLOAD(MAXP),
    .START_CODE(8'hFE), .END_CODE(8'hEF), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .uart_data(uart_data), .rx_interrupt(rx_interrupt),
    .clear_interrupt(clear_interrupt),
    .cmd_valid(cmd_valid), .cmd_onehot(cmd_onehot),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_idx(pay_idx),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // frame model: 0 idle, 1 len, 2 cmd, 3 payload, 4 end
  int         m_st, m_len, m_code, m_cnt, m_idle;
  logic [4:0] m_oh;
  logic [1:0] m_ec;
  logic       m_take;
  logic       e_pv, e_cv, e_fe;
  logic [7:0] e_pd;
  int         e_pi;

  logic [7:0] q_pay[$];
  int         n_cv = 0, n_fe = 0, n_clr = 0, n_sent = 0;
  int         cv0, fe0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_len = 0; m_code = 0; m_cnt = 0; m_idle = 0;
    m_oh = '0; m_ec = '0; m_take = 1'b0;
    e_pv = 0; e_cv = 0; e_fe = 0; e_pd = '0; e_pi = 0;
  endtask

  task automatic model_err(input logic [1:0] c);
    e_fe = 1'b1; m_ec = c; m_st = 0;
    m_len = 0; m_code = 0; m_cnt = 0; m_idle = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_st)
      0: if (b == 8'hFE) m_st = 1;
      1: begin
        if (int'(b) > MAXP) model_err(2'd1);
        else begin m_len = int'(b); m_cnt = 0; m_st = 2; end
      end
      2: begin
        if (b == 0 || int'(b) > NCMD) model_err(2'd0);
        else begin m_code = int'(b); m_st = (m_len > 0) ? 3 : 4; end
      end
      3: begin
        e_pv = 1'b1; e_pd = b; e_pi = m_cnt;
        m_cnt++;
        if (m_cnt == m_len) m_st = 4;
      end
      default: begin
        if (b == 8'hEF) begin
          e_cv = 1'b1;
          m_oh = 5'(1 << (m_code - 1));
        end else model_err(2'd2);
        m_st = 0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      chk("clear_interrupt", clear_interrupt, m_take);
      chk("pay_valid", pay_valid, e_pv);
      chk("cmd_valid", cmd_valid, e_cv);
      chk("frame_err", frame_err, e_fe);
      chk("cmd_onehot", cmd_onehot, m_oh);
      chk("err_code", err_code, m_ec);
      if (e_pv) begin
        chk("pay_data", pay_data, e_pd);
        chk("pay_idx", pay_idx, e_pi);
      end
      if (pay_valid) q_pay.push_back(pay_data);
      if (cmd_valid) n_cv++;
      if (frame_err) n_fe++;
      if (clear_interrupt) n_clr++;
      e_pv = 0; e_cv = 0; e_fe = 0;
      if (m_take) begin
        m_idle = 0;
        model_byte(uart_data);
      end else if (!rx_interrupt && m_st != 0) begin
        m_idle++;
        if (m_idle == TO) model_err(2'd3);
      end
      // byte seen at the coming edge is taken unless this cycle already was
      m_take = rx_interrupt && !m_take;
    end
  end

  task automatic send(input logic [7:0] b);
    int k;
    @(posedge clk); #1;
    uart_data = b; rx_interrupt = 1'b1; n_sent++;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!clear_interrupt && k < 10);
    if (!clear_interrupt) begin
      n_chk++;
      $display("FAIL clr_wait got=0 exp=1 byte=%0h", b);
    end
    @(posedge clk); #1;
    rx_interrupt = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(posedge clk);
    if ($urandom_range(0, 49) == 0) repeat (TO + 5) @(posedge clk);
  endtask

  task automatic snap();
    q_pay.delete(); cv0 = n_cv; fe0 = n_fe;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_clr"}, clear_interrupt, 0);
    chk({nm, "_cv"}, cmd_valid, 0);
    chk({nm, "_oh"}, cmd_onehot, 0);
    chk({nm, "_pd"}, pay_data, 0);
    chk({nm, "_pv"}, pay_valid, 0);
    chk({nm, "_pi"}, pay_idx, 0);
    chk({nm, "_fe"}, frame_err, 0);
    chk({nm, "_ec"}, err_code, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_interrupt = 1'b0; uart_data = '0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    chk_zero("por");
    rst = 1'b0;
    idle(2);

    snap();
    send(8'hFE); send(8'h02); send(8'h04);
    send(8'h11); send(8'h22); send(8'hEF);
    idle(3);
    chk("t1_npay", q_pay.size(), 2);
    chk("t1_p0", q_pay[0], 8'h11);
    chk("t1_p1", q_pay[1], 8'h22);
    chk("t1_cv", n_cv - cv0, 1);
    chk("t1_oh", cmd_onehot, 5'b01000);

    snap();
    send(8'h33); send(8'h44);
    send(8'hFE); send(8'h00); send(8'h01); send(8'hEF);
    idle(3);
    chk("t2_npay", q_pay.size(), 0);
    chk("t2_cv", n_cv - cv0, 1);
    chk("t2_fe", n_fe - fe0, 0);
    chk("t2_oh", cmd_onehot, 5'b00001);

    snap();
    send(8'hFE); send(8'h11);
    idle(3);
    chk("badlen_ec", err_code, 1);
    chk("badlen_fe", n_fe - fe0, 1);
    snap();
    send(8'hFE); send(8'h00); send(8'h06);
    idle(3);
    chk("badcmd_ec", err_code, 0);
    chk("badcmd_fe", n_fe - fe0, 1);
    snap();
    send(8'hFE); send(8'h01); send(8'h02);
    send(8'h55); send(8'hAA);
    idle(3);
    chk("badend_ec", err_code, 2);
    chk("badend_fe", n_fe - fe0, 1);
    chk("badend_oh", cmd_onehot, 5'b00001);

    snap();
    send(8'hFE); send(8'h02); send(8'h03);
    send(8'hFE); send(8'hEF); send(8'hEF);
    idle(3);
    chk("t4_npay", q_pay.size(), 2);
    chk("t4_p0", q_pay[0], 8'hFE);
    chk("t4_p1", q_pay[1], 8'hEF);
    chk("t4_oh", cmd_onehot, 5'b00100);

    snap();
    send(8'hFE); send(8'h03);
    idle(TO + 10);
    chk("to_ec", err_code, 3);
    chk("to_fe", n_fe - fe0, 1);
    snap();
    send(8'hFE); send(8'h00); send(8'h02); send(8'hEF);
    idle(3);
    chk("to_next_cv", n_cv - cv0, 1);
    chk("to_next_oh", cmd_onehot, 5'b00010);

    snap();
    send(8'hFE); send(8'h02); send(8'h04); send(8'h11);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("midrst_fe", n_fe - fe0, 0);
    snap();
    send(8'hFE); send(8'h01); send(8'h05);
    send(8'h77); send(8'hEF);
    idle(3);
    chk("post_rst_npay", q_pay.size(), 1);
    chk("post_rst_p0", q_pay[0], 8'h77);
    chk("post_rst_oh", cmd_onehot, 5'b10000);

    for (int f = 0; f < 250; f++) begin
      int r, len, code;
      r    = $urandom_range(0, 99);
      len  = (r < 20) ? $urandom_range(0, MAXP + 1) : $urandom_range(0, 4);
      code = (r < 30) ? $urandom_range(0, NCMD + 2) : $urandom_range(1, NCMD);
      if (r < 10) begin send(8'($urandom_range(0, 255))); gap(); end
      send(8'hFE); gap();
      send(8'(len)); gap();
      send(8'(code)); gap();
      for (int i = 0; i < len; i++) begin
        send(8'($urandom_range(0, 255))); gap();
      end
      send((r < 40) ? 8'($urandom_range(0, 255)) : 8'hEF);
      gap();
    end
    idle(TO + 10);
    chk("clr_per_byte", n_clr, n_sent);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Parametrised UART command-frame parser, next generation of the command FSM between the UART receiver and the processor datapath. Consumes bytes on the `rx_interrupt`/`clear_interrupt` handshake and decodes frames `START, LEN, CMD, payload[LEN], END`. Emits a one-hot command strobe and level, a per-byte payload stream with index, and classified frame errors with inter-byte timeout. Adds length-driven payload extraction, command-count generalisation and error reporting.

## Interface
- `DATA_W`, 8: UART byte width.
- `NUM_CMDS`, 5: number of valid command codes; valid codes are 1..`NUM_CMDS`.
- `MAX_PAYLOAD`, 16: largest accepted `LEN` value (≥1).
- `START_CODE`, 8'hFE: frame start byte.
- `END_CODE`, 8'hEF: frame end byte.
- `TIMEOUT_CYC`, 1_000_000: idle cycles tolerated between bytes mid-frame; 0 disables timeout.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_data`  in  DATA_W  received byte; valid while `rx_interrupt`=1.
- `rx_interrupt`  in  1  byte-available level from UART; held until cleared.
- `clear_interrupt`  out  1  one-cycle acknowledge; UART drops `rx_interrupt` next cycle.
- `cmd_valid`  out  1  one-cycle pulse on a correctly terminated frame.
- `cmd_onehot`  out  NUM_CMDS  bit (CMD-1) of last valid frame; held level.
- `pay_data`  out  DATA_W  current payload byte.
- `pay_valid`  out  1  one-cycle pulse per payload byte.
- `pay_idx`  out  $clog2(MAX_PAYLOAD)  index of `pay_data` in frame, 0-based.
- `frame_err`  out  1  one-cycle pulse on frame abort.
- `err_code`  out  2  0 BAD_CMD, 1 BAD_LEN, 2 BAD_END, 3 TIMEOUT; holds last error.

## Operation
- Handshake FSM: WAIT -> TAKE when `rx_interrupt`=1; TAKE asserts `clear_interrupt`, samples `uart_data`, advances frame FSM, returns to WAIT. Max one byte per 2 cycles.
- Frame FSM (advances only in TAKE):
  - IDLE: byte==START_CODE -> LEN; any other byte discarded silently, no error.
  - LEN: LEN>MAX_PAYLOAD -> BAD_LEN, IDLE; else store LEN, clear payload counter -> CMD.
  - CMD: code 0 or >NUM_CMDS -> BAD_CMD, IDLE; else store code -> PAYLOAD if LEN>0, else END.
  - PAYLOAD: output byte with `pay_valid`, `pay_idx`=counter; counter+1; counter==LEN-1 -> END. START_CODE/END_CODE bytes here are plain data.
  - END: byte==END_CODE -> `cmd_valid` pulse, `cmd_onehot` updated to stored code, IDLE; else BAD_END, IDLE.
- `cmd_onehot` unchanged on any error; payload already emitted for an aborted frame is not retracted.
- Timeout: counter clears on every TAKE; increments each WAIT cycle while frame FSM ≠ IDLE and `rx_interrupt`=0; reaching TIMEOUT_CYC -> TIMEOUT error, IDLE, counter cleared.
- Error abort: `frame_err` pulse, `err_code` updated, frame FSM to IDLE, stored LEN/code/counter cleared.

## Timing
- Reset values: `clear_interrupt` 0, `cmd_valid` 0, `cmd_onehot` 0, `pay_data` 0, `pay_valid` 0, `pay_idx` 0, `frame_err` 0, `err_code` 0; both FSMs WAIT/IDLE; counters 0.
- `rx_interrupt` sampled high at edge t -> `clear_interrupt`=1 during cycle t..t+1 (exactly one cycle).
- `pay_valid`, `cmd_valid`, `frame_err`, `pay_data`, `pay_idx`, `err_code` registered: valid the cycle after TAKE, one-cycle pulses.
- `rx_interrupt` still high in the cycle after `clear_interrupt` is a UART fault; block treats it as a new byte.
- Timeout and `rx_interrupt` same cycle: byte wins, no timeout.
- `rst` mid-frame: all state and outputs to reset values immediately; partial frame discarded without `frame_err`.

## Test plan
- Frame FE,02,04,11,22,EF -> `pay_valid` twice (11 idx0, 22 idx1), then `cmd_valid` pulse, `cmd_onehot`=5'b01000.
- Frame FE,00,01,EF -> no `pay_valid`, `cmd_valid` pulse, `cmd_onehot`=5'b00001; garbage 33,44 before FE ignored, no `frame_err`.
- FE,11,... with MAX_PAYLOAD=16 -> BAD_LEN (`err_code`=1) after LEN byte; FE,00,06 -> BAD_CMD (0); FE,01,02,55,AA -> BAD_END (2), `cmd_onehot` unchanged.
- Payload containing FE,EF: FE,02,03,FE,EF,EF -> payload FE,EF emitted, frame valid, `cmd_onehot`=5'b00100.
- TIMEOUT_CYC=20: FE,03 then silence -> `frame_err`, `err_code`=3 20 cycles after last TAKE; subsequent FE,00,02,EF valid.
- Assert `rst` after FE,02,04,11 -> outputs zero, no `frame_err`; next full frame decodes normally; `clear_interrupt` one cycle per byte throughout.
